// File: rtl/gray_counter_n_if.sv
// gray_counter_n_if
//   Control and status bundle for gray_counter_n.
//   master : drives clr, ld, ld_val, en, up, cmp_val; observes bin, gray, tc, match
//   slave  : the counter itself (inverse directions)
//   WIDTH must match the WIDTH of the counter it is connected to.
interface gray_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             tc;
  logic             match;

  modport master (
    output clr, ld, ld_val, en, up, cmp_val,
    input  bin, gray, tc, match
  );

  modport slave (
    input  clr, ld, ld_val, en, up, cmp_val,
    output bin, gray, tc, match
  );
endinterface

// File: rtl/gray_counter_n.sv
// gray_counter_n
//   Parametrised up/down Gray-code counter with clear, load, enable,
//   wrap or saturate at the limits, compare-match and terminal-event flags.
//   Binary and Gray values are both held in flops, so the Gray bus is
//   glitch-free and safe to sample from another clock domain.
// Parameters:
//   WIDTH    : counter width in bits (2..32)
//   SATURATE : 0 = wrap modulo 2^WIDTH, 1 = hold at the limit
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears every output register
//   bus  : gray_counter_n_if.slave
//          in  clr, ld, ld_val, en, up, cmp_val
//          out bin, gray, tc, match (all registered)
module gray_counter_n #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  gray_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;
  logic             r_match;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_at_limit;
  logic             w_tc_next;

  // Next binary value; priority clr > ld > en > hold.
  // tc marks an enabled step taken from the limit in the current direction:
  // a wrap when wrapping, a blocked step when saturating.
  always_comb begin
    w_next     = r_bin;
    w_at_limit = 1'b0;
    w_tc_next  = 1'b0;
    if (bus.clr) begin
      w_next = '0;
    end else if (bus.ld) begin
      w_next = bus.ld_val;
    end else if (bus.en) begin
      w_at_limit = bus.up ? (r_bin == ALL_ONES) : (r_bin == '0);
      w_tc_next  = w_at_limit;
      if (w_at_limit && SATURATE) begin
        w_next = r_bin;
      end else if (bus.up) begin
        w_next = r_bin + ONE;
      end else begin
        w_next = r_bin - ONE;
      end
    end
  end

  // Gray image of the next value, so the gray flops load together with bin
  // and are never decoded from the bin flops after the edge.
  assign w_gray_next[WIDTH-1] = w_next[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH-1; gi++) begin : g_gray
      assign w_gray_next[gi] = w_next[gi+1] ^ w_next[gi];
    end
  endgenerate

  // match compares the value being loaded, so it lines up with the bin
  // value it describes on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_tc    <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_bin   <= w_next;
      r_gray  <= w_gray_next;
      r_tc    <= w_tc_next;
      r_match <= (w_next == bus.cmp_val);
    end
  end

  assign bus.bin   = r_bin;
  assign bus.gray  = r_gray;
  assign bus.tc    = r_tc;
  assign bus.match = r_match;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n
//   Four counters share clk/rst: WIDTH=4 wrapping, WIDTH=4 saturating,
//   WIDTH=2 and WIDTH=32 wrapping. Each task drives one scenario; expected
//   outputs are pushed to sb_q when a cycle's stimulus is driven and popped
//   when the DUT output for that cycle is sampled 1 ns after the edge.
module tb_gray_counter_n;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gray_counter_n_if #(.WIDTH(4))  if4w ();
  gray_counter_n_if #(.WIDTH(4))  if4s ();
  gray_counter_n_if #(.WIDTH(2))  if2  ();
  gray_counter_n_if #(.WIDTH(32)) if32 ();

  gray_counter_n #(.WIDTH(4),  .SATURATE(1'b0)) u_w4  (.clk(clk), .rst(rst), .bus(if4w));
  gray_counter_n #(.WIDTH(4),  .SATURATE(1'b1)) u_s4  (.clk(clk), .rst(rst), .bus(if4s));
  gray_counter_n #(.WIDTH(2),  .SATURATE(1'b0)) u_w2  (.clk(clk), .rst(rst), .bus(if2));
  gray_counter_n #(.WIDTH(32), .SATURATE(1'b0)) u_w32 (.clk(clk), .rst(rst), .bus(if32));

  typedef struct packed {
    logic [31:0] bin;
    logic [31:0] gray;
    logic        tc;
    logic        match;
  } exp_t;

  // One directed cycle for a WIDTH=4 counter: stimulus plus expected result.
  typedef struct packed {
    logic       clr;
    logic       ld;
    logic [3:0] ldv;
    logic       en;
    logic       up;
    logic [3:0] cmp;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    logic       m;
  } row4_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] gray_of(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic idle_all();
    if4w.clr = 1'b0; if4w.ld = 1'b0; if4w.en = 1'b0; if4w.up = 1'b0; if4w.ld_val = '0;
    if4s.clr = 1'b0; if4s.ld = 1'b0; if4s.en = 1'b0; if4s.up = 1'b0; if4s.ld_val = '0;
    if2.clr  = 1'b0; if2.ld  = 1'b0; if2.en  = 1'b0; if2.up  = 1'b0; if2.ld_val  = '0;
    if32.clr = 1'b0; if32.ld = 1'b0; if32.en = 1'b0; if32.up = 1'b0; if32.ld_val = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    idle_all();
    if4w.cmp_val = '0; if4s.cmp_val = '0; if2.cmp_val = '0; if32.cmp_val = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_w4: got bin=%0h gray=%b tc=%b match=%b, expected all 0", if4w.bin, if4w.gray, if4w.tc, if4w.match);
    end
    n_checks++;
    if ({if4s.bin, if4s.gray, if4s.tc, if4s.match} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_s4: got bin=%0h gray=%b tc=%b match=%b, expected all 0", if4s.bin, if4s.gray, if4s.tc, if4s.match);
    end
    n_checks++;
    if ({if2.bin, if2.gray, if2.tc, if2.match} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_w2: got bin=%0h gray=%b tc=%b match=%b, expected all 0", if2.bin, if2.gray, if2.tc, if2.match);
    end
    n_checks++;
    if ({if32.bin, if32.gray, if32.tc, if32.match} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_w32: got bin=%0h gray=%0h tc=%b match=%b, expected all 0", if32.bin, if32.gray, if32.tc, if32.match);
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_release_w4: got bin=%0h gray=%b tc=%b match=%b, expected all 0", if4w.bin, if4w.gray, if4w.tc, if4w.match);
    end
    // First edge after release: match now evaluates bin 0 against cmp_val 0.
    sb_q.push_back('{bin: 32'd0, gray: 32'd0, tc: 1'b0, match: 1'b1});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_checks++;
    if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
      n_fail++;
      $display("FAIL first_edge_match: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
               if4w.bin, if4w.gray, if4w.tc, if4w.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
    end
  endtask

  task automatic test_wrap_up();
    exp_t       e;
    logic [3:0] prev;
    prev = if4w.gray;
    if4w.cmp_val = 4'd0;
    if4w.en = 1'b1;
    if4w.up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      sb_q.push_back('{bin: 32'(i % 16), gray: gray_of(32'(i % 16)), tc: (i == 16), match: (i == 16)});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
        n_fail++;
        $display("FAIL wrap_up step %0d: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
                 i, if4w.bin, if4w.gray, if4w.tc, if4w.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
      end
      n_checks++;
      if ($countones(if4w.gray ^ prev) != 1) begin
        n_fail++;
        $display("FAIL wrap_up_gray_step %0d: got %0d changed bits (%b -> %b), expected 1", i, $countones(if4w.gray ^ prev), prev, if4w.gray);
      end
      prev = if4w.gray;
    end
    idle_all();
  endtask

  task automatic test_down_wrap();
    exp_t  e;
    row4_t tbl [2];
    tbl = '{
      '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd14, 4'b1001, 1'b0, 1'b0}
    };
    for (int i = 0; i < 2; i++) begin
      if4w.clr = tbl[i].clr; if4w.ld = tbl[i].ld; if4w.ld_val = tbl[i].ldv;
      if4w.en = tbl[i].en; if4w.up = tbl[i].up; if4w.cmp_val = tbl[i].cmp;
      sb_q.push_back('{bin: 32'(tbl[i].bin), gray: 32'(tbl[i].gray), tc: tbl[i].tc, match: tbl[i].m});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
        n_fail++;
        $display("FAIL down_wrap step %0d: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
                 i, if4w.bin, if4w.gray, if4w.tc, if4w.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
      end
    end
    idle_all();
  endtask

  task automatic test_load_clear();
    exp_t  e;
    row4_t tbl [6];
    tbl = '{
      '{1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 4'd0, 4'd5,  4'b0111, 1'b0, 1'b0},  // ld beats en
      '{1'b1, 1'b1, 4'd9,  1'b0, 1'b0, 4'd0, 4'd0,  4'b0000, 1'b0, 1'b1},  // clr beats ld
      '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 4'd0, 4'd9,  4'b1101, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b0, 1'b0},  // ld at limit: no wrap, no tc
      '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 4'd0,  4'b0000, 1'b0, 1'b1}   // clr beats en at limit
    };
    for (int i = 0; i < 6; i++) begin
      if4w.clr = tbl[i].clr; if4w.ld = tbl[i].ld; if4w.ld_val = tbl[i].ldv;
      if4w.en = tbl[i].en; if4w.up = tbl[i].up; if4w.cmp_val = tbl[i].cmp;
      sb_q.push_back('{bin: 32'(tbl[i].bin), gray: 32'(tbl[i].gray), tc: tbl[i].tc, match: tbl[i].m});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
        n_fail++;
        $display("FAIL load_clear step %0d: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
                 i, if4w.bin, if4w.gray, if4w.tc, if4w.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
      end
    end
    idle_all();
  endtask

  task automatic test_saturate();
    exp_t  e;
    row4_t tbl [8];
    tbl = '{
      '{1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 4'd0, 4'd14, 4'b1001, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0,  4'b0000, 1'b0, 1'b1},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 4'd0,  4'b0000, 1'b1, 1'b1},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 4'd0,  4'b0000, 1'b1, 1'b1},
      '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0,  4'b0000, 1'b0, 1'b1}
    };
    for (int i = 0; i < 8; i++) begin
      if4s.clr = tbl[i].clr; if4s.ld = tbl[i].ld; if4s.ld_val = tbl[i].ldv;
      if4s.en = tbl[i].en; if4s.up = tbl[i].up; if4s.cmp_val = tbl[i].cmp;
      sb_q.push_back('{bin: 32'(tbl[i].bin), gray: 32'(tbl[i].gray), tc: tbl[i].tc, match: tbl[i].m});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if4s.bin, if4s.gray, if4s.tc, if4s.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
        n_fail++;
        $display("FAIL saturate step %0d: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
                 i, if4s.bin, if4s.gray, if4s.tc, if4s.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
      end
    end
    idle_all();
  endtask

  task automatic test_compare();
    exp_t  e;
    row4_t tbl [7];
    tbl = '{
      '{1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd3, 4'd1, 4'b0001, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 4'd2, 4'b0011, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 4'd3, 4'b0010, 1'b0, 1'b1},
      '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 4'd4, 4'b0110, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 4'd3, 4'b0010, 1'b0, 1'b1},
      '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 4'd3, 4'b0010, 1'b0, 1'b0},  // cmp_val moves away
      '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 4'd3, 4'b0010, 1'b0, 1'b1}
    };
    for (int i = 0; i < 7; i++) begin
      if4w.clr = tbl[i].clr; if4w.ld = tbl[i].ld; if4w.ld_val = tbl[i].ldv;
      if4w.en = tbl[i].en; if4w.up = tbl[i].up; if4w.cmp_val = tbl[i].cmp;
      sb_q.push_back('{bin: 32'(tbl[i].bin), gray: 32'(tbl[i].gray), tc: tbl[i].tc, match: tbl[i].m});
      if (i == 5) begin
        // cmp_val has changed but no edge yet: match must still show the old result.
        #3;
        n_checks++;
        if (if4w.match !== 1'b1) begin
          n_fail++;
          $display("FAIL compare_no_comb_path: got match=%b, expected 1 before the edge", if4w.match);
        end
      end
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
        n_fail++;
        $display("FAIL compare step %0d: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
                 i, if4w.bin, if4w.gray, if4w.tc, if4w.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
      end
    end
    idle_all();
  endtask

  task automatic test_width_sweep();
    exp_t        e;
    logic        en_v, up_v;
    logic [1:0]  m2, n2, p2;
    logic [31:0] m32, n32, p32;
    logic        ntc;

    // WIDTH=2, cmp_val=2
    if2.cmp_val = 2'd2;
    m2 = if2.bin == 2'd0 ? 2'd0 : 2'd0;
    m2 = 2'd0;
    p2 = if2.gray;
    for (int i = 0; i < 80; i++) begin
      en_v = 1'($urandom_range(0, 1));
      up_v = 1'($urandom_range(0, 1));
      if2.en = en_v; if2.up = up_v;
      n2  = m2;
      ntc = 1'b0;
      if (en_v) begin
        if (up_v) begin ntc = (m2 == 2'd3); n2 = m2 + 2'd1; end
        else      begin ntc = (m2 == 2'd0); n2 = m2 - 2'd1; end
      end
      sb_q.push_back('{bin: 32'(n2), gray: gray_of(32'(n2)), tc: ntc, match: (n2 == 2'd2)});
      m2 = n2;
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if2.bin, if2.gray, if2.tc, if2.match} !== {e.bin[1:0], e.gray[1:0], e.tc, e.match}) begin
        n_fail++;
        $display("FAIL sweep_w2 cycle %0d: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
                 i, if2.bin, if2.gray, if2.tc, if2.match, e.bin[1:0], e.gray[1:0], e.tc, e.match);
      end
      n_checks++;
      if (if2.gray !== (if2.bin ^ (if2.bin >> 1))) begin
        n_fail++;
        $display("FAIL sweep_w2_gray_rel cycle %0d: got gray=%b, expected %b", i, if2.gray, if2.bin ^ (if2.bin >> 1));
      end
      if (en_v) begin
        n_checks++;
        if ($countones(if2.gray ^ p2) != 1) begin
          n_fail++;
          $display("FAIL sweep_w2_one_bit cycle %0d: got %0d changed bits, expected 1", i, $countones(if2.gray ^ p2));
        end
      end
      p2 = if2.gray;
    end
    idle_all();

    // WIDTH=32, cmp_val=0
    if32.cmp_val = 32'd0;
    m32 = 32'd0;
    p32 = if32.gray;
    for (int i = 0; i < 80; i++) begin
      en_v = 1'($urandom_range(0, 1));
      up_v = 1'($urandom_range(0, 1));
      if32.en = en_v; if32.up = up_v;
      n32 = m32;
      ntc = 1'b0;
      if (en_v) begin
        if (up_v) begin ntc = (m32 == 32'hFFFF_FFFF); n32 = m32 + 32'd1; end
        else      begin ntc = (m32 == 32'd0);         n32 = m32 - 32'd1; end
      end
      sb_q.push_back('{bin: n32, gray: gray_of(n32), tc: ntc, match: (n32 == 32'd0)});
      m32 = n32;
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if32.bin, if32.gray, if32.tc, if32.match} !== {e.bin, e.gray, e.tc, e.match}) begin
        n_fail++;
        $display("FAIL sweep_w32 cycle %0d: got bin=%0h gray=%0h tc=%b match=%b, expected bin=%0h gray=%0h tc=%b match=%b",
                 i, if32.bin, if32.gray, if32.tc, if32.match, e.bin, e.gray, e.tc, e.match);
      end
      n_checks++;
      if (if32.gray !== (if32.bin ^ (if32.bin >> 1))) begin
        n_fail++;
        $display("FAIL sweep_w32_gray_rel cycle %0d: got gray=%0h, expected %0h", i, if32.gray, if32.bin ^ (if32.bin >> 1));
      end
      if (en_v) begin
        n_checks++;
        if ($countones(if32.gray ^ p32) != 1) begin
          n_fail++;
          $display("FAIL sweep_w32_one_bit cycle %0d: got %0d changed bits, expected 1", i, $countones(if32.gray ^ p32));
        end
      end
      p32 = if32.gray;
    end

    // WIDTH=32 wrap: load all-ones, then one up step
    if32.en = 1'b0; if32.ld = 1'b1; if32.ld_val = 32'hFFFF_FFFF;
    sb_q.push_back('{bin: 32'hFFFF_FFFF, gray: 32'h8000_0000, tc: 1'b0, match: 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_checks++;
    if ({if32.bin, if32.gray, if32.tc, if32.match} !== {e.bin, e.gray, e.tc, e.match}) begin
      n_fail++;
      $display("FAIL w32_load_ones: got bin=%0h gray=%0h tc=%b match=%b, expected bin=%0h gray=%0h tc=%b match=%b",
               if32.bin, if32.gray, if32.tc, if32.match, e.bin, e.gray, e.tc, e.match);
    end
    if32.ld = 1'b0; if32.en = 1'b1; if32.up = 1'b1;
    sb_q.push_back('{bin: 32'd0, gray: 32'd0, tc: 1'b1, match: 1'b1});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_checks++;
    if ({if32.bin, if32.gray, if32.tc, if32.match} !== {e.bin, e.gray, e.tc, e.match}) begin
      n_fail++;
      $display("FAIL w32_wrap: got bin=%0h gray=%0h tc=%b match=%b, expected bin=%0h gray=%0h tc=%b match=%b",
               if32.bin, if32.gray, if32.tc, if32.match, e.bin, e.gray, e.tc, e.match);
    end
    idle_all();
  endtask

  task automatic test_async_reset();
    exp_t e;
    // if4w holds 3 from the compare scenario
    if4w.cmp_val = 4'd5; if4w.en = 1'b1; if4w.up = 1'b1;
    for (int i = 4; i <= 5; i++) begin
      sb_q.push_back('{bin: 32'(i), gray: gray_of(32'(i)), tc: 1'b0, match: (i == 5)});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
        n_fail++;
        $display("FAIL async_pre step %0d: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
                 i, if4w.bin, if4w.gray, if4w.tc, if4w.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
      end
    end
    // Mid-cycle pulse: outputs must clear without waiting for an edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got bin=%0h gray=%b tc=%b match=%b, expected all 0", if4w.bin, if4w.gray, if4w.tc, if4w.match);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset_held: got bin=%0h gray=%b tc=%b match=%b, expected all 0", if4w.bin, if4w.gray, if4w.tc, if4w.match);
    end
    rst = 1'b0;
    sb_q.push_back('{bin: 32'd1, gray: 32'd1, tc: 1'b0, match: 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_checks++;
    if ({if4w.bin, if4w.gray, if4w.tc, if4w.match} !== {e.bin[3:0], e.gray[3:0], e.tc, e.match}) begin
      n_fail++;
      $display("FAIL async_resume: got bin=%0h gray=%b tc=%b match=%b, expected bin=%0h gray=%b tc=%b match=%b",
               if4w.bin, if4w.gray, if4w.tc, if4w.match, e.bin[3:0], e.gray[3:0], e.tc, e.match);
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_wrap();
    test_load_clear();
    test_saturate();
    test_compare();
    test_width_sweep();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter and successor to the team's fixed 4-bit counter. It adds configurable width, up/down direction, enable, synchronous clear and load, a wrap/saturate mode, compare-match and terminal-event flags. Binary and Gray outputs both come straight from flops. This makes the Gray bus glitch-free, so it can be sampled in another clock domain (FIFO pointers, position counters).

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32
- SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = hold at limit

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear to 0
- ld  in  1  synchronous load of ld_val
- ld_val  in  WIDTH  binary load value
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- cmp_val  in  WIDTH  binary compare value
- bin  out  WIDTH  registered binary count
- gray  out  WIDTH  registered Gray count, gray == bin ^ (bin >> 1)
- tc  out  1  registered terminal event flag
- match  out  1  registered compare flag, bin == cmp_val

## Operation
- Priority per cycle: clr > ld > en > hold.
- clr: next = 0.
- ld: next = ld_val, taken verbatim. up and en are ignored.
- en and up: next = bin + 1, modulo 2^WIDTH.
- en and !up: next = bin - 1, modulo 2^WIDTH.
- SATURATE=1:
  - An increment from all-ones leaves the count at all-ones.
  - A decrement from 0 leaves the count at 0.
- No state machine. State is the bin, gray, tc and match registers, all updated on the same edge.
- The gray register is loaded from next ^ (next >> 1), computed from the next binary value. It is never decoded combinationally from the bin flops.
- Between consecutive enabled steps (no clr or ld), gray changes in exactly 1 bit; this holds across wrap too. A hold changes 0 bits. A clr or ld may change any number of bits.
- tc is set for one cycle after an enabled step that met the limit:
  - SATURATE=0: a wrap, up all-ones -> 0 or down 0 -> all-ones.
  - SATURATE=1: a blocked step at the limit. tc stays high on every such cycle while en is held.
  - Otherwise tc = 0. clr and ld force tc = 0.
- match <= (next == cmp_val), so match aligns with the bin value it describes. A cmp_val change is reflected one cycle later.
- Arithmetic is WIDTH bits only. No carry-out port.

## Timing
- Reset values: bin = 0, gray = 0, tc = 0, match = 0.
  - match is 0 during reset even if cmp_val == 0.
  - match first evaluates on the first clock edge after reset release.
- Latency: one cycle from inputs (clr/ld/en/up/ld_val/cmp_val) to all outputs. No combinational input-to-output path.
- Reset assertion mid-count clears all outputs immediately, with no clock needed. Counting resumes on the first edge after deassertion.
- Simultaneous events:
  - clr with ld: clr wins, bin = 0.
  - ld with en: loaded value is held, no extra step that cycle.
  - Direction change is permitted on any cycle; the step uses the current up value.
- Throughput: one step per clock with en held high.

## Test plan
- Reset and wrap-up count, WIDTH=4, SATURATE=0:
  - After reset release, outputs are bin=0, gray=0000, tc=0, match=0.
  - en=1, up=1 for 16 cycles: bin steps 0..15 then 0.
  - Gray has exactly one bit change per step; 15 -> 0 goes gray 1000 -> 0000 with tc=1 for exactly that one cycle.
- Down wrap, WIDTH=4:
  - From 0 with en=1, up=0: bin becomes 15, gray 1000, tc=1.
  - The next step gives bin=14, gray 1001, tc=0.
- Load/clear priority, WIDTH=4:
  - ld=1, ld_val=5, en=1 gives bin=5, gray 0111, tc=0.
  - Then clr=1, ld=1, ld_val=9 gives bin=0.
  - Then ld=1 alone, ld_val=9 gives bin=9, gray 1101.
- Saturate, WIDTH=4, SATURATE=1:
  - Load 14, then en=1, up=1 for 3 cycles: bin 15, 15, 15; tc = 0, 1, 1.
  - Down from 0 holds at 0 with tc=1.
- Compare: cmp_val=3; load 1, then count up.
  - match=1 only on the cycle where bin=3.
  - Then cmp_val changed to 4 while holding at 3: match drops one cycle later.
- Width sweep, WIDTH=2 and WIDTH=32:
  - Free-run with random en/up; a scoreboard checks gray == bin ^ (bin >> 1) each cycle and the single-bit-change property on enabled steps.
  - WIDTH=32 wraps: load 0xFFFFFFFF, up step gives bin 0, tc=1.
  - Async reset pulse mid-count zeroes outputs before the next edge.
